alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
- REQ-001: Parameter WIDTH, default 4, operand/result width; the shared ALU supports only 4.
- REQ-002: CLK  input  1  sole clock; all state updates on rising edge.
- REQ-003: RST_N  input  1  asynchronous, active-low reset.
- REQ-004: REQ0_VALID / REQ1_VALID  input  1 each  requester n presents an operation.
- REQ-005: REQ0_READY / REQ1_READY  output  1 each  operation n accepted this cycle.
- REQ-006: REQ0_IN1, REQ0_IN2, REQ1_IN1, REQ1_IN2  input  WIDTH each  operands.
- REQ-007: REQ0_OP / REQ1_OP  input  3 each  opcode: 000 add, 001 sub, 010 and, 011 or, 100 not IN1.
- REQ-008: ALU_IN1, ALU_IN2  output  WIDTH each and ALU_CONTROL  output  3  drive the shared combinational ALU.
- REQ-009: ALU_RESULT  input  WIDTH and ALU_N, ALU_Z, ALU_C, ALU_V  input  1 each  ALU response.
- REQ-010: RSP_VALID  output  1  response available; RSP_READY  input  1  consumer accepts.
- REQ-011: RSP_ID  output  1  index of the requester being answered.
- REQ-012: RSP_RESULT  output  WIDTH and RSP_FLAGS  output  4  {N,Z,C,V} captured from ALU.
- REQ-013: RSP_ERR  output  1  illegal opcode rejected (see Configuration).

Function
- REQ-014: The FSM SHALL have states IDLE, EXEC, RESP.
- REQ-015: IDLE: if any REQn_VALID, assert READY to exactly one winner combinationally, latch its IN1/IN2/OP/ID, go to EXEC; otherwise remain in IDLE.
- REQ-016: Arbitration SHALL be round-robin: a single requester wins alone; when both are valid, the one not granted last wins; LAST_GNT updates on each grant.
- REQ-017: REQn_READY SHALL be 0 in EXEC and RESP, and never high for both requesters together.
- REQ-018: EXEC: ALU_IN1/ALU_IN2/ALU_CONTROL SHALL be driven from the latched registers; RESULT and flags captured at the end of EXEC; go to RESP.
- REQ-019: Outside EXEC, ALU_* outputs SHALL hold the last latched values (no glitching to the requester inputs).
- REQ-020: RESP: RSP_VALID=1 with RSP_ID/RESULT/FLAGS/ERR stable; on RSP_READY=1 go to IDLE; hold indefinitely while RSP_READY=0.
- REQ-021: Latency SHALL be: acceptance in cycle T, RSP_VALID high from cycle T+2; maximum throughput one operation per 3 cycles.
- REQ-022: Requesters SHALL hold VALID and operands until READY; a VALID dropped before grant is simply not served.
- REQ-023: RSP_READY while RSP_VALID=0 SHALL have no effect.

Reset
- REQ-024: RST_N low SHALL force IDLE, LAST_GNT=1 (requester 0 wins the first tie), all latched operand/response registers to 0, RSP_VALID=0, RSP_ERR=0, READY=0 immediately.
- REQ-025: Reset asserted in EXEC or RESP SHALL discard the in-flight operation without a response.

Configuration
- REQ-026: With ALU_ARB_OPCHK_EN defined, opcodes 101/110/111 SHALL be accepted but not issued: EXEC drives ALU_CONTROL=000 and the response has RSP_RESULT=0, RSP_FLAGS=0000, RSP_ERR=1.
- REQ-027: Without ALU_ARB_OPCHK_EN, all opcodes SHALL pass through to the ALU unchanged and RSP_ERR SHALL be tied to 0.

Structure
- REQ-028: A shared package SHALL hold the opcode constants (OP_ADD..OP_NOT), the FSM state enum, and the flag bit indices (N=3, Z=2, C=1, V=0).
- REQ-029: The round-robin selection SHALL live in a sub-module alu_rr_arb (inputs: two valids, LAST_GNT; outputs: one-hot grant, winner index).

Verification
- REQ-030: REQ0 add 0011+0101 -> RSP_ID=0, RSP_RESULT=1000, RSP_FLAGS=1001 (N=1,V=1), RSP_VALID exactly at T+2.
- REQ-031: REQ1 sub 0101-0101 -> RSP_ID=1, RSP_RESULT=0000, RSP_FLAGS=0110 (Z=1,C=1).
- REQ-032: Both valid from the first cycle after reset, RSP_READY=1 -> grants in order 0,1,0,1; no double READY.
- REQ-033: RSP_READY held 0 for 5 cycles during RESP -> response fields stable, both READY remain 0, one response delivered on release.
- REQ-034: With ALU_ARB_OPCHK_EN, opcode 110 -> RSP_ERR=1, RSP_RESULT=0000, RSP_FLAGS=0000; without the macro -> RSP_ERR=0, RSP_RESULT=0000, Z=1.
- REQ-035: RST_N pulsed low during EXEC -> RSP_VALID never rises for that operation; the next tie is granted to requester 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: opcodes, FSM states and flag bit positions shared by the ALU arbiter.
package alu_arbiter_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    function automatic logic op_illegal(input logic [2:0] op);
        return op > OP_NOT;
    endfunction
endpackage

// File: rtl/alu_rr_arb.sv
// alu_rr_arb: two-way round-robin pick; a lone requester always wins, a tie goes to
// the requester not granted last.
module alu_rr_arb
    import alu_arbiter_pkg::*;
(
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_last_gnt,
    output logic [1:0] o_gnt,
    output logic       o_idx
);
    always_comb begin
        o_idx = (i_valid0 && i_valid1) ? ~i_last_gnt : i_valid1;
        o_gnt = (i_valid0 || i_valid1) ? (o_idx ? 2'b10 : 2'b01) : 2'b00;
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters (IDLE->EXEC->RESP).
// Define ALU_ARB_OPCHK_EN to reject opcodes 101..111 with RSP_ERR instead of issuing them.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    input  logic             i_req1_valid,
    output logic             o_req0_ready,
    output logic             o_req1_ready,
    input  logic [WIDTH-1:0] i_req0_in1,
    input  logic [WIDTH-1:0] i_req0_in2,
    input  logic [WIDTH-1:0] i_req1_in1,
    input  logic [WIDTH-1:0] i_req1_in2,
    input  logic [2:0]       i_req0_op,
    input  logic [2:0]       i_req1_op,
    output logic [WIDTH-1:0] o_alu_in1,
    output logic [WIDTH-1:0] o_alu_in2,
    output logic [2:0]       o_alu_control,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_n,
    input  logic             i_alu_z,
    input  logic             i_alu_c,
    input  logic             i_alu_v,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic [3:0]       o_rsp_flags,
    output logic             o_rsp_err
);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_in1, r_in2, r_result;
    logic [2:0]       r_op;
    logic [3:0]       r_flags, w_flags;
    logic             r_id, r_last_gnt;
    logic [1:0]       w_gnt;
    logic             w_idx, w_accept, w_illegal;

    alu_rr_arb u_arb (
        .i_valid0   (i_req0_valid),
        .i_valid1   (i_req1_valid),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_gnt),
        .o_idx      (w_idx)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = |w_gnt;
                w_next   = w_accept ? EXEC : IDLE;
            end
            EXEC:    w_next = RESP;
            RESP:    w_next = i_rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_N] = i_alu_n;
        w_flags[FLAG_Z] = i_alu_z;
        w_flags[FLAG_C] = i_alu_c;
        w_flags[FLAG_V] = i_alu_v;
    end

    // Ready is masked by reset so it drops the moment reset asserts.
    assign o_req0_ready  = w_accept & w_gnt[0] & i_rst_n;
    assign o_req1_ready  = w_accept & w_gnt[1] & i_rst_n;
    assign o_rsp_valid   = (r_state == RESP);
    assign o_rsp_id      = r_id;
    assign o_rsp_result  = r_result;
    assign o_rsp_flags   = r_flags;
    assign o_alu_in1     = r_in1;
    assign o_alu_in2     = r_in2;
    assign o_alu_control = w_illegal ? OP_ADD : r_op;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_in1      <= '0;
            r_in2      <= '0;
            r_op       <= '0;
            r_id       <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_in1      <= w_idx ? i_req1_in1 : i_req0_in1;
                r_in2      <= w_idx ? i_req1_in2 : i_req0_in2;
                r_op       <= w_idx ? i_req1_op : i_req0_op;
                r_id       <= w_idx;
                r_last_gnt <= w_idx;
            end
            if (r_state == EXEC) begin
                r_result <= w_illegal ? '0 : i_alu_result;
                r_flags  <= w_illegal ? '0 : w_flags;
            end
        end
    end

`ifdef ALU_ARB_OPCHK_EN
    logic r_err;
    assign w_illegal = op_illegal(r_op);
    assign o_rsp_err = r_err;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_err <= 1'b0;
        else if (r_state == EXEC)
            r_err <= w_illegal;
    end
`else
    assign w_illegal = 1'b0;
    assign o_rsp_err = 1'b0;
`endif
endmodule
